// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: shared definitions for the microcoded sequencer.
//   - FSM state encoding
//   - default field widths
//   - microword flag positions (the four flags sit in the top nibble of the word)
package micro_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } seq_state_t;

    localparam int unsigned DEF_ADDR_W  = 3;
    localparam int unsigned DEF_OP_W    = 2;
    localparam int unsigned DEF_SHAMT_W = 2;
    localparam int unsigned DEF_DEPTH   = 16;

    localparam int unsigned NUM_FLAGS = 4;

    // Flag offsets relative to the LSB of the flag nibble.
    localparam int unsigned FLAG_WE   = 0;
    localparam int unsigned FLAG_OE   = 1;
    localparam int unsigned FLAG_IE   = 2;
    localparam int unsigned FLAG_LAST = 3;

    // Bit index of the lowest flag; everything below it is the packed field area
    // (WriteAddr, ReadAddrA, ReadAddrB, ALUOpcode, SHAMT from high to low).
    function automatic int unsigned flags_lsb(input int unsigned addr_w,
                                              input int unsigned op_w,
                                              input int unsigned shamt_w);
        return shamt_w + op_w + 3 * addr_w;
    endfunction

endpackage

// File: rtl/micro_store.sv
// micro_store: DEPTH x UW microcode register array.
//   clk     : write clock, rising edge
//   wr_en   : write strobe
//   wr_addr : write address (out-of-range addresses are dropped)
//   wr_data : word to write
//   rd_addr : read address
//   rd_data : asynchronous read data
// The array has no reset; contents are undefined until written.
module micro_store #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned UW    = 17,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [UW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [UW-1:0] rd_data
);

    logic [UW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/micro_seq_ctrl.sv
// micro_seq_ctrl: programmable microcode sequencer driving datapath control enables.
//   Clk_i, Reset_n_i        : clock (rising edge), async active-low reset
//   Start_i                 : start the program at PC=0 (accepted in IDLE only)
//   InValid_i, OutReady_i   : input/output handshakes; a step that needs one stalls until it is high
//   ProgWrEn_i/Addr_i/Data_i: microcode write port (IDLE only)
//   Busy_o, Done_o, PC_o    : sequence status, one-cycle completion pulse, current step
//   InputEn_o .. SHAMT_o    : decoded microword fields, all zero outside RUN
// Microword MSB->LSB: Last, InputEn, OutputEn, WriteEn, WriteAddr, ReadAddrA, ReadAddrB,
// ALUOpcode, SHAMT.
// Optional feature macro STEP_MODE_EN: adds Step_i; in RUN a step only executes (PC advances,
// WriteEn_o asserts) in a cycle where Step_i is high and the step is not stalled.
module micro_seq_ctrl
    import micro_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned OP_W    = DEF_OP_W,
    parameter int unsigned SHAMT_W = DEF_SHAMT_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned PC_W    = $clog2(DEPTH),
    parameter int unsigned UW      = NUM_FLAGS + 3 * ADDR_W + OP_W + SHAMT_W
) (
    input  logic               Clk_i,
    input  logic               Reset_n_i,
    input  logic               Start_i,
`ifdef STEP_MODE_EN
    input  logic               Step_i,
`endif
    input  logic               InValid_i,
    input  logic               OutReady_i,
    input  logic               ProgWrEn_i,
    input  logic [PC_W-1:0]    ProgAddr_i,
    input  logic [UW-1:0]      ProgData_i,
    output logic               Busy_o,
    output logic               Done_o,
    output logic [PC_W-1:0]    PC_o,
    output logic               InputEn_o,
    output logic               WriteEn_o,
    output logic               OutputEn_o,
    output logic [ADDR_W-1:0]  WriteAddr_o,
    output logic [ADDR_W-1:0]  ReadAddr_A_o,
    output logic [ADDR_W-1:0]  ReadAddr_B_o,
    output logic [OP_W-1:0]    ALUOpcode_o,
    output logic [SHAMT_W-1:0] SHAMT_o
);

    localparam int unsigned OP_LSB    = SHAMT_W;
    localparam int unsigned RB_LSB    = OP_LSB + OP_W;
    localparam int unsigned RA_LSB    = RB_LSB + ADDR_W;
    localparam int unsigned WA_LSB    = RA_LSB + ADDR_W;
    localparam int unsigned FLAGS_LSB = flags_lsb(ADDR_W, OP_W, SHAMT_W);
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(DEPTH - 1);

    seq_state_t      state_q;
    logic [PC_W-1:0] pc_q;
    logic            busy_q;
    logic            done_q;

    logic [UW-1:0]   word;
    logic            run;
    logic            stall;
    logic            advance;
    logic            is_last;

    // Program writes are only honoured while idle so a running program cannot be altered.
    micro_store #(
        .DEPTH (DEPTH),
        .UW    (UW),
        .AW    (PC_W)
    ) u_store (
        .clk     (Clk_i),
        .wr_en   (ProgWrEn_i && (state_q == StIdle)),
        .wr_addr (ProgAddr_i),
        .wr_data (ProgData_i),
        .rd_addr (pc_q),
        .rd_data (word)
    );

    assign run   = (state_q == StRun);
    assign stall = (word[FLAGS_LSB + FLAG_IE] & ~InValid_i)
                 | (word[FLAGS_LSB + FLAG_OE] & ~OutReady_i);
`ifdef STEP_MODE_EN
    assign advance = run & ~stall & Step_i;
`else
    assign advance = run & ~stall;
`endif
    // Running off the end of the store terminates the program like an explicit Last.
    assign is_last = word[FLAGS_LSB + FLAG_LAST] | (pc_q == PC_MAX);

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q <= StIdle;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (Start_i) begin
                        state_q <= StRun;
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    if (advance) begin
                        if (is_last) begin
                            state_q <= StDone;
                            pc_q    <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q <= pc_q + PC_W'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    pc_q    <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy_o = busy_q;
    assign Done_o = done_q;
    assign PC_o   = pc_q;

    // Field decode is gated by RUN; WriteEn only fires on the cycle the step actually executes.
    always_comb begin
        InputEn_o    = 1'b0;
        WriteEn_o    = 1'b0;
        OutputEn_o   = 1'b0;
        WriteAddr_o  = '0;
        ReadAddr_A_o = '0;
        ReadAddr_B_o = '0;
        ALUOpcode_o  = '0;
        SHAMT_o      = '0;
        if (run) begin
            InputEn_o    = word[FLAGS_LSB + FLAG_IE];
            OutputEn_o   = word[FLAGS_LSB + FLAG_OE];
            WriteEn_o    = word[FLAGS_LSB + FLAG_WE] & advance;
            WriteAddr_o  = word[WA_LSB +: ADDR_W];
            ReadAddr_A_o = word[RA_LSB +: ADDR_W];
            ReadAddr_B_o = word[RB_LSB +: ADDR_W];
            ALUOpcode_o  = word[OP_LSB +: OP_W];
            SHAMT_o      = word[0 +: SHAMT_W];
        end
    end

endmodule
